// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the cache/main-memory arbitration slice.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } arb_state_t;

  localparam int BLK_OFF_W  = 4;
  localparam int WORD_IDX_W = 3;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/blk_fill_ctr.sv
// Issue (k) and return (r) word counters for one block fill; shared by both caches.
module blk_fill_ctr
  import cpu_mem_pkg::*;
#(
  parameter int WORDS_PER_BLK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  ret,
  output logic                  issue_active,
  output logic [WORD_IDX_W-1:0] k,
  output logic [WORD_IDX_W-1:0] r,
  output logic                  last_ret,
  output logic                  ret_done
);

  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_BLK - 1);

  logic                  issue_q;
  logic [WORD_IDX_W-1:0] k_q;
  logic [WORD_IDX_W-1:0] r_q;
  logic                  done_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      issue_q <= 1'b0;
      k_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else if (start) begin
      issue_q <= 1'b1;
      k_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      if (issue_q) begin
        if (k_q == LAST_IDX) issue_q <= 1'b0;
        else                 k_q     <= k_q + WORD_IDX_W'(1);
      end
      // Returns beyond the last word are dropped rather than wrapping r.
      if (ret && !done_q) begin
        if (r_q == LAST_IDX) done_q <= 1'b1;
        else                 r_q    <= r_q + WORD_IDX_W'(1);
      end
    end
  end

  assign issue_active = issue_q;
  assign k            = k_q;
  assign r            = r_q;
  assign last_ret     = (r_q == LAST_IDX);
  assign ret_done     = done_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared main-memory port between I-cache fills and D-cache
// fills/write-throughs; fill words are returned tagged with their block index.
module cache_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int MEM_LAT       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  i_grant,
  output logic                  d_grant,
  output logic [DATA_W-1:0]     fill_data,
  output logic [WORD_IDX_W-1:0] fill_idx,
  output logic                  i_data_vld,
  output logic                  d_data_vld,
  output logic                  i_fill_done,
  output logic                  d_fill_done,
  output logic                  d_wr_done,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvld,
  output arb_state_t            dbg_state
);

  // Handshake: a requester raises *_req and holds it (with stable address/data)
  // until its done pulse; address/data are captured at the grant edge, and the
  // requester drops *_req in the cycle after done, which the arbiter spends in IDLE.

  if (MEM_LAT < 1 || WORDS_PER_BLK != (1 << WORD_IDX_W)) begin : g_param_chk
    $error("cache_mem_arbiter: unsupported MEM_LAT/WORDS_PER_BLK");
  end

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       grant_i, grant_d;
  logic       wr_issued_q;
  logic       in_fill, ret_ok;

  logic [ADDR_W-BLK_OFF_W-1:0] base_q;
  logic [ADDR_W-1:0]           wr_addr_q;
  logic [DATA_W-1:0]           wr_data_q;

  logic                  issue_active, last_ret, ret_done;
  logic [WORD_IDX_W-1:0] k, r;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[BLK_OFF_W-1:0], d_addr[0]};

  assign in_fill = (state_q == I_FILL) || (state_q == D_FILL);
  assign ret_ok  = in_fill && mem_rvld && !ret_done;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          if (last_grant_q == REQ_I) grant_d = 1'b1;
          else                       grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end
        if (grant_d) begin
          state_d      = d_wr ? D_WRITE : D_FILL;
          last_grant_d = REQ_D;
        end else if (grant_i) begin
          state_d      = I_FILL;
          last_grant_d = REQ_I;
        end
      end
      I_FILL, D_FILL: if (ret_ok && last_ret) state_d = IDLE;
      D_WRITE:        if (wr_issued_q) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
      base_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_issued_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (grant_i) base_q <= i_addr[ADDR_W-1:BLK_OFF_W];
      if (grant_d) begin
        base_q    <= d_addr[ADDR_W-1:BLK_OFF_W];
        wr_addr_q <= {d_addr[ADDR_W-1:1], 1'b0};
        wr_data_q <= d_wdata;
      end
      wr_issued_q <= (state_q == D_WRITE) && !wr_issued_q;
    end
  end

  blk_fill_ctr #(.WORDS_PER_BLK(WORDS_PER_BLK)) u_ctr (
    .clk          (clk),
    .rst          (rst),
    .start        (grant_i || (grant_d && !d_wr)),
    .clear        (ret_ok && last_ret),
    .ret          (in_fill && mem_rvld),
    .issue_active (issue_active),
    .k            (k),
    .r            (r),
    .last_ret     (last_ret),
    .ret_done     (ret_done)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (in_fill && issue_active) begin
      mem_en   = 1'b1;
      mem_addr = {base_q, k, 1'b0};
    end else if (state_q == D_WRITE && !wr_issued_q) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = wr_addr_q;
      mem_wdata = wr_data_q;
    end
  end

  assign i_grant     = (state_q == I_FILL);
  assign d_grant     = (state_q == D_FILL) || (state_q == D_WRITE);
  assign fill_data   = ret_ok ? mem_rdata : '0;
  assign fill_idx    = ret_ok ? r : '0;
  assign i_data_vld  = ret_ok && (state_q == I_FILL);
  assign d_data_vld  = ret_ok && (state_q == D_FILL);
  assign i_fill_done = i_data_vld && last_ret;
  assign d_fill_done = d_data_vld && last_ret;
  assign d_wr_done   = (state_q == D_WRITE) && wr_issued_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed plus randomized checks of cache_mem_arbiter against a transaction-level model.
module tb_cache_mem_arbiter;
  import cpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, d_grant;
  logic [15:0] fill_data;
  logic [2:0]  fill_idx;
  logic        i_data_vld, d_data_vld, i_fill_done, d_fill_done, d_wr_done;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvld;
  arb_state_t  dbg_state;

  int          vectors = 0;
  int          miscompares = 0;
  logic        last_grant_m;
  logic [15:0] key;
  logic        stray;

  logic [59:0] all_outs;
  assign all_outs = {i_grant, d_grant, i_data_vld, d_data_vld, i_fill_done, d_fill_done,
                     d_wr_done, mem_en, mem_wr, fill_idx, fill_data, mem_addr, mem_wdata};

  // clock / reset
  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_grant(i_grant), .d_grant(d_grant),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_data_vld(i_data_vld), .d_data_vld(d_data_vld),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_done(d_wr_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvld(mem_rvld),
    .dbg_state(dbg_state)
  );

  // memory model: a read issued in cycle c returns in cycle c+4, data = addr ^ key
  logic [3:0]  pv;
  logic [15:0] pa [0:3];
  always @(posedge clk) begin
    if (rst) pv <= '0;
    else     pv <= {pv[2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
  end
  assign mem_rvld  = pv[3] | stray;
  assign mem_rdata = pa[3] ^ key;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = I fill, 1 = D fill, 2 = D write-through
  task automatic set_req(input int kind, input logic [15:0] addr, input logic [15:0] wdata);
    if (kind == 0) begin
      i_req  = 1'b1;
      i_addr = addr;
    end else begin
      d_req   = 1'b1;
      d_wr    = (kind == 2);
      d_addr  = addr;
      d_wdata = wdata;
    end
  endtask

  task automatic idle_tail(input int kind);
    @(negedge clk);
    if (kind == 0) i_req = 1'b0;
    else           d_req = 1'b0;
    chk("idle_outs", 64'(all_outs), 64'd0);
    chk("idle_state", 64'(dbg_state), 64'(IDLE));
  endtask

  // Checks ncyc cycles of a fill whose grant edge is the next posedge.
  task automatic expect_fill(input bit is_i, input logic [15:0] addr, input int ncyc);
    logic [1:0]  side;
    logic [15:0] blk;
    side = is_i ? 2'b10 : 2'b01;
    blk  = {addr[15:4], 4'h0};
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk("fill_grant", 64'({i_grant, d_grant}), 64'(side));
      chk("fill_state", 64'(dbg_state), is_i ? 64'(I_FILL) : 64'(D_FILL));
      chk("fill_mem_en", 64'(mem_en), 64'(c < 8));
      chk("fill_mem_addr", 64'(mem_addr), c < 8 ? 64'(blk + 16'(2 * c)) : 64'd0);
      chk("fill_mem_wr", 64'(mem_wr), 64'd0);
      if (c >= 8) chk("fill_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("fill_vld", 64'({i_data_vld, d_data_vld}), c >= 4 ? 64'(side) : 64'd0);
      if (c >= 4) begin
        chk("fill_idx", 64'(fill_idx), 64'(c - 4));
        chk("fill_data", 64'(fill_data), 64'((blk + 16'(2 * (c - 4))) ^ key));
      end
      chk("fill_done", 64'({i_fill_done, d_fill_done, d_wr_done}),
          c == 11 ? 64'({side, 1'b0}) : 64'd0);
      if (c == 0) begin
        if (is_i) i_addr = 16'($urandom);
        else      d_addr = 16'($urandom);
      end
    end
    if (ncyc == 12) idle_tail(is_i ? 0 : 1);
  endtask

  task automatic expect_write(input logic [15:0] addr, input logic [15:0] wdata, input bit stray_on);
    stray = stray_on;
    @(negedge clk);
    chk("wr_grant", 64'({i_grant, d_grant}), 64'(2'b01));
    chk("wr_state", 64'(dbg_state), 64'(D_WRITE));
    chk("wr_mem_en", 64'({mem_en, mem_wr}), 64'(2'b11));
    chk("wr_mem_addr", 64'(mem_addr), 64'({addr[15:1], 1'b0}));
    chk("wr_mem_wdata", 64'(mem_wdata), 64'(wdata));
    chk("wr_vld0", 64'({i_data_vld, d_data_vld}), 64'd0);
    chk("wr_done0", 64'({i_fill_done, d_fill_done, d_wr_done}), 64'd0);
    d_addr  = 16'($urandom);
    d_wdata = 16'($urandom);
    @(negedge clk);
    chk("wr_grant1", 64'({i_grant, d_grant}), 64'(2'b01));
    chk("wr_mem_off", 64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'd0);
    chk("wr_vld1", 64'({i_data_vld, d_data_vld}), 64'd0);
    chk("wr_done1", 64'({i_fill_done, d_fill_done, d_wr_done}), 64'(3'b001));
    idle_tail(2);
    stray = 1'b0;
  endtask

  task automatic do_txn(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                        input bit stray_on);
    case (kind)
      0:       expect_fill(1'b1, addr, 12);
      1:       expect_fill(1'b0, addr, 12);
      default: expect_write(addr, wdata, stray_on);
    endcase
    last_grant_m = (kind == 0) ? 1'b0 : 1'b1;
  endtask

  // Both requesters raised together; the one not granted last goes first.
  task automatic do_pair(input logic [15:0] ia, input int dkind, input logic [15:0] da,
                         input logic [15:0] dw);
    set_req(0, ia, 16'h0);
    set_req(dkind, da, dw);
    if (last_grant_m == 1'b0) begin
      do_txn(dkind, da, dw, 1'b0);
      do_txn(0, ia, 16'h0, 1'b0);
    end else begin
      do_txn(0, ia, 16'h0, 1'b0);
      do_txn(dkind, da, dw, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    key = 16'h0; stray = 1'b0; last_grant_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'(all_outs), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", 64'(all_outs), 64'd0);

    // stray return while idle
    stray = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_idle", 64'(all_outs), 64'd0);
    end
    stray = 1'b0;

    // simultaneous first requests: D wins the first tie
    do_pair(16'h0100, 1, 16'h0040, 16'h0);

    // I-only fill
    set_req(0, 16'h1236, 16'h0);
    do_txn(0, 16'h1236, 16'h0, 1'b0);

    // fairness: D alone, then both pending -> I first
    set_req(1, 16'h0480, 16'h0);
    do_txn(1, 16'h0480, 16'h0, 1'b0);
    do_pair(16'h0700, 1, 16'h0900, 16'h0);

    // write-through with stray returns during D_WRITE and the following IDLE
    set_req(2, 16'h00A5, 16'hBEEF);
    do_txn(2, 16'h00A5, 16'hBEEF, 1'b1);
    set_req(1, 16'h0C00, 16'h0);
    do_txn(1, 16'h0C00, 16'h0, 1'b0);

    // reset after the third returned word of an I fill
    set_req(0, 16'h3450, 16'h0);
    expect_fill(1'b1, 16'h3450, 7);
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk("midrst_outs", 64'(all_outs), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    last_grant_m = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_quiet", 64'(all_outs), 64'd0);
    end
    set_req(0, 16'h2000, 16'h0);
    do_txn(0, 16'h2000, 16'h0, 1'b0);

    // randomized mix of single and contending transactions
    for (int n = 0; n < 16; n++) begin
      int          mode;
      logic [15:0] a0, a1, wd;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      key  = 16'($urandom);
      mode = $urandom_range(0, 3);
      a0   = 16'($urandom);
      a1   = 16'($urandom);
      wd   = 16'($urandom);
      if (mode < 3) begin
        set_req(mode, a0, wd);
        do_txn(mode, a0, wd, 1'($urandom_range(0, 1)));
      end else begin
        do_pair(a0, $urandom_range(1, 2), a1, wd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
